// File: rtl/reset_sequencer_if.sv
// reset_sequencer_if: status inputs and reset/status outputs of the reset sequencer
// master: used by reset_sequencer (takes lock/done status, drives resets, ready, fail, state)
// slave : used by the environment (drives lock/done status, observes the outputs)
interface reset_sequencer_if;
    logic       mmcm_locked;
    logic       mig_calib_done;
    logic       gt_init_done;
    logic       rst_mig;
    logic       rst_gt;
    logic       rst_app;
    logic       ready;
    logic       fail;
    logic [2:0] state;
    modport master (
        input  mmcm_locked, mig_calib_done, gt_init_done,
        output rst_mig, rst_gt, rst_app, ready, fail, state
    );
    modport slave (
        output mmcm_locked, mig_calib_done, gt_init_done,
        input  rst_mig, rst_gt, rst_app, ready, fail, state
    );
endinterface

// File: rtl/reset_sequencer.sv
// reset_sequencer: releases MIG, GT and application resets in order after MMCM lock, with retry/fail
// clk_sys   : system clock, rising edge
// rst_sys_n : synchronous active-low reset
// bus       : async lock/done status in; rst_mig/rst_gt/rst_app, ready, sticky fail, debug state out
module reset_sequencer #(
    parameter int HOLD_LEN    = 1000,
    parameter int LOCK_STABLE = 256,
    parameter int TIMEOUT     = 1000000,
    parameter int MAX_RETRY   = 3
) (
    input  logic               clk_sys,
    input  logic               rst_sys_n,
    reset_sequencer_if.master  bus
);
    localparam int M1      = HOLD_LEN > LOCK_STABLE ? HOLD_LEN : LOCK_STABLE;
    localparam int CNT_MAX = M1 > TIMEOUT ? M1 : TIMEOUT;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int RW      = $clog2(MAX_RETRY + 1);
    typedef enum logic [2:0] {
        WAIT_LOCK, MIG_RST, MIG_CAL, GT_RST, GT_INIT, RUN, FAILED
    } state_t;
    // bit [1] of each pair is the synchronized value
    logic [1:0]    lock_q, cal_q, gt_q;
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [RW-1:0] retry_q, retry_d, retry_inc;
    logic          rst_mig_q, rst_gt_q, rst_app_q, ready_q, fail_q;
    logic          locked_s, calib_s, gt_done_s;
    logic          hold_done, time_out, adv, do_retry, lock_lost;
    assign locked_s  = lock_q[1];
    assign calib_s   = cal_q[1];
    assign gt_done_s = gt_q[1];
    assign hold_done = cnt_q == CW'(HOLD_LEN - 1);
    assign time_out  = cnt_q == CW'(TIMEOUT - 1);
    assign retry_inc = retry_q + RW'(1);
    assign lock_lost = !locked_s && state_q != WAIT_LOCK && state_q != FAILED;
    always_comb begin
        adv      = 1'b0;
        do_retry = 1'b0;
        case (state_q)
            WAIT_LOCK: adv = locked_s && cnt_q == CW'(LOCK_STABLE - 1);
            MIG_RST:   adv = hold_done;
            MIG_CAL:   begin adv = calib_s; do_retry = !calib_s && time_out; end
            GT_RST:    adv = hold_done;
            GT_INIT:   begin adv = gt_done_s; do_retry = !gt_done_s && time_out; end
            RUN:       do_retry = !calib_s || !gt_done_s;
            default:   ;
        endcase
        state_d = state_q;
        retry_d = retry_q;
        // lock loss outranks both done and timeout, and is not a failed attempt
        if (lock_lost)
            state_d = WAIT_LOCK;
        else if (adv)
            state_d = state_t'(state_q + 3'd1);
        else if (do_retry) begin
            retry_d = retry_inc;
            state_d = retry_inc == RW'(MAX_RETRY) ? FAILED : WAIT_LOCK;
        end
        if (state_d == RUN && state_q != RUN)
            retry_d = '0;
        // one shared counter: cleared on any state change and while waiting without lock
        cnt_d = (state_d != state_q || (state_q == WAIT_LOCK && !locked_s)) ? '0 :
                cnt_q + CW'(cnt_q != CW'(CNT_MAX));
    end
    always_ff @(posedge clk_sys) begin
        if (!rst_sys_n) begin
            lock_q    <= '0;
            cal_q     <= '0;
            gt_q      <= '0;
            state_q   <= WAIT_LOCK;
            cnt_q     <= '0;
            retry_q   <= '0;
            rst_mig_q <= 1'b1;
            rst_gt_q  <= 1'b1;
            rst_app_q <= 1'b1;
            ready_q   <= 1'b0;
            fail_q    <= 1'b0;
        end else begin
            lock_q    <= {lock_q[0], bus.mmcm_locked};
            cal_q     <= {cal_q[0], bus.mig_calib_done};
            gt_q      <= {gt_q[0], bus.gt_init_done};
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            retry_q   <= retry_d;
            rst_mig_q <= state_d inside {WAIT_LOCK, MIG_RST, FAILED};
            rst_gt_q  <= !(state_d inside {GT_INIT, RUN});
            rst_app_q <= state_d != RUN;
            ready_q   <= state_d == RUN;
            fail_q    <= state_d == FAILED;
        end
    end
    assign bus.rst_mig = rst_mig_q;
    assign bus.rst_gt  = rst_gt_q;
    assign bus.rst_app = rst_app_q;
    assign bus.ready   = ready_q;
    assign bus.fail    = fail_q;
    assign bus.state   = state_q;
endmodule
